// File: rtl/b_preadd_stage.sv
// B-path pre-adder stage: optional B0/D/OPMODE input registers, D +/- B pre-add or B bypass, optional B1 output register.
// Latency B0REG+B1REG (B), DREG+B1REG (D), OPMODEREG+B1REG (OPMODE); no backpressure, CE low holds each register.
module b_preadd_stage #(
   parameter int B0REG     = 1,
   parameter int DREG      = 1,
   parameter int B1REG     = 1,
   parameter int OPMODEREG = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CEB,
   input  logic        CED,
   input  logic        CEOPMODE,
   input  logic [17:0] B_BCIN_stg,
   input  logic [17:0] D,
   input  logic [1:0]  OPMODE_PRE,
   output logic [17:0] B1_OUT,
   output logic [17:0] BCOUT
);

   logic [17:0] b0;
   logic [17:0] d_q;
   logic [1:0]  op_q;
   logic [17:0] pre_sum;
   logic [17:0] b1_d;

   // Control inputs go unused when every stage is built combinational.
   logic unused_ctrl;
   assign unused_ctrl = ^{CLK, RST_N, CEB, CED, CEOPMODE};

   generate
      if (B0REG != 0) begin : g_b0_reg
         logic [17:0] b0_q;
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)   b0_q <= '0;
            else if (CEB) b0_q <= B_BCIN_stg;
         end
         assign b0 = b0_q;
      end else begin : g_b0_comb
         assign b0 = B_BCIN_stg;
      end

      if (DREG != 0) begin : g_d_reg
         logic [17:0] dr_q;
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)   dr_q <= '0;
            else if (CED) dr_q <= D;
         end
         assign d_q = dr_q;
      end else begin : g_d_comb
         assign d_q = D;
      end

      if (OPMODEREG != 0) begin : g_op_reg
         logic [1:0] opr_q;
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)        opr_q <= '0;
            else if (CEOPMODE) opr_q <= OPMODE_PRE;
         end
         assign op_q = opr_q;
      end else begin : g_op_comb
         assign op_q = OPMODE_PRE;
      end
   endgenerate

   // 18-bit result width drops the carry/borrow, giving modulo-2^18 arithmetic.
   always_comb begin
      pre_sum = op_q[1] ? (d_q - b0) : (d_q + b0);
      b1_d    = op_q[0] ? pre_sum : b0;
   end

   generate
      if (B1REG != 0) begin : g_b1_reg
         logic [17:0] b1_q;
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)   b1_q <= '0;
            else if (CEB) b1_q <= b1_d;
         end
         assign B1_OUT = b1_q;
      end else begin : g_b1_comb
         assign B1_OUT = b1_d;
      end
   endgenerate

   assign BCOUT = B1_OUT;

endmodule

// File: tb/tb_b_preadd_stage.sv
// Directed bench for b_preadd_stage: default registered instance plus an all-combinational instance.
module tb_b_preadd_stage;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CEB = 1'b1, CED = 1'b1, CEOPMODE = 1'b1;
   logic [17:0] B_BCIN_stg = '0, D = '0;
   logic [1:0]  OPMODE_PRE = '0;
   logic [17:0] B1_OUT, BCOUT;

   logic        c_rst_n = 1'b1;
   logic [17:0] c_b = '0, c_d = '0;
   logic [1:0]  c_op = '0;
   logic [17:0] c_out, c_bcout;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   b_preadd_stage dut (
      .CLK(CLK), .RST_N(RST_N), .CEB(CEB), .CED(CED), .CEOPMODE(CEOPMODE),
      .B_BCIN_stg(B_BCIN_stg), .D(D), .OPMODE_PRE(OPMODE_PRE),
      .B1_OUT(B1_OUT), .BCOUT(BCOUT)
   );

   b_preadd_stage #(.B0REG(0), .DREG(0), .B1REG(0), .OPMODEREG(0)) dut_comb (
      .CLK(CLK), .RST_N(c_rst_n), .CEB(1'b1), .CED(1'b1), .CEOPMODE(1'b1),
      .B_BCIN_stg(c_b), .D(c_d), .OPMODE_PRE(c_op),
      .B1_OUT(c_out), .BCOUT(c_bcout)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      D = 18'h00ABC; B_BCIN_stg = 18'h00123; OPMODE_PRE = 2'b01;
      #1;
      checks++;
      if (B1_OUT !== 18'h0) begin failures++; $display("FAIL reset_b1 got=%h exp=%h", B1_OUT, 18'h0); end
      checks++;
      if (BCOUT !== 18'h0) begin failures++; $display("FAIL reset_bcout got=%h exp=%h", BCOUT, 18'h0); end
   endtask

   task automatic test_add();
      D = 18'd5; B_BCIN_stg = 18'd3; OPMODE_PRE = 2'b01;
      #1 RST_N = 1'b1;
      tick();
      checks++;
      if (B1_OUT !== 18'd0) begin failures++; $display("FAIL add_edge1 got=%h exp=%h", B1_OUT, 18'd0); end
      tick();
      checks++;
      if (B1_OUT !== 18'd8) begin failures++; $display("FAIL add_edge2 got=%h exp=%h", B1_OUT, 18'd8); end
      checks++;
      if (BCOUT !== 18'd8) begin failures++; $display("FAIL add_bcout got=%h exp=%h", BCOUT, 18'd8); end
   endtask

   task automatic test_wrap();
      D = 18'd0; B_BCIN_stg = 18'd1; OPMODE_PRE = 2'b11;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h3FFFF) begin failures++; $display("FAIL wrap_sub got=%h exp=%h", B1_OUT, 18'h3FFFF); end
      D = 18'h3FFFF; B_BCIN_stg = 18'd1; OPMODE_PRE = 2'b01;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h0) begin failures++; $display("FAIL wrap_add got=%h exp=%h", B1_OUT, 18'h0); end
      D = 18'h01234; B_BCIN_stg = 18'h01234; OPMODE_PRE = 2'b11;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h0) begin failures++; $display("FAIL equal_sub got=%h exp=%h", B1_OUT, 18'h0); end
   endtask

   task automatic test_bypass();
      D = 18'h3FFFF; B_BCIN_stg = 18'h12345; OPMODE_PRE = 2'b00;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h12345) begin failures++; $display("FAIL bypass got=%h exp=%h", B1_OUT, 18'h12345); end
      // Subtract bit alone must not engage the pre-adder.
      OPMODE_PRE = 2'b10;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h12345) begin failures++; $display("FAIL bypass_subbit got=%h exp=%h", B1_OUT, 18'h12345); end
   endtask

   task automatic test_ceb_hold();
      OPMODE_PRE = 2'b00; B_BCIN_stg = 18'h00007;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h00007) begin failures++; $display("FAIL ceb_load got=%h exp=%h", B1_OUT, 18'h00007); end
      CEB = 1'b0; B_BCIN_stg = 18'h00100;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (B1_OUT !== 18'h00007) begin failures++; $display("FAIL ceb_hold%0d got=%h exp=%h", i, B1_OUT, 18'h00007); end
      end
      CEB = 1'b1;
      tick();
      checks++;
      if (B1_OUT !== 18'h00007) begin failures++; $display("FAIL ceb_resume1 got=%h exp=%h", B1_OUT, 18'h00007); end
      tick();
      checks++;
      if (B1_OUT !== 18'h00100) begin failures++; $display("FAIL ceb_resume2 got=%h exp=%h", B1_OUT, 18'h00100); end
   endtask

   task automatic test_ced_ceop();
      OPMODE_PRE = 2'b01; B_BCIN_stg = 18'd1; D = 18'd2;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'd3) begin failures++; $display("FAIL ced_base got=%h exp=%h", B1_OUT, 18'd3); end
      CEB = 1'b0; D = 18'd10;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'd3) begin failures++; $display("FAIL ced_b1hold got=%h exp=%h", B1_OUT, 18'd3); end
      CEB = 1'b1; CED = 1'b0; D = 18'd99;
      tick();
      checks++;
      if (B1_OUT !== 18'd11) begin failures++; $display("FAIL ced_advanced got=%h exp=%h", B1_OUT, 18'd11); end
      CEOPMODE = 1'b0; OPMODE_PRE = 2'b11;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'd11) begin failures++; $display("FAIL ceop_hold got=%h exp=%h", B1_OUT, 18'd11); end
      CEOPMODE = 1'b1;
      tick();
      checks++;
      if (B1_OUT !== 18'd11) begin failures++; $display("FAIL ceop_edge1 got=%h exp=%h", B1_OUT, 18'd11); end
      tick();
      checks++;
      if (B1_OUT !== 18'd9) begin failures++; $display("FAIL ceop_edge2 got=%h exp=%h", B1_OUT, 18'd9); end
      CED = 1'b1;
   endtask

   task automatic test_reset_mid();
      OPMODE_PRE = 2'b00; B_BCIN_stg = 18'h00155;
      tick(); tick();
      checks++;
      if (B1_OUT !== 18'h00155) begin failures++; $display("FAIL rmid_load got=%h exp=%h", B1_OUT, 18'h00155); end
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if (B1_OUT !== 18'h0) begin failures++; $display("FAIL rmid_async got=%h exp=%h", B1_OUT, 18'h0); end
      checks++;
      if (BCOUT !== 18'h0) begin failures++; $display("FAIL rmid_bcout got=%h exp=%h", BCOUT, 18'h0); end
      #1 RST_N = 1'b1;
      tick();
      checks++;
      if (B1_OUT !== 18'h0) begin failures++; $display("FAIL rmid_edge1 got=%h exp=%h", B1_OUT, 18'h0); end
      tick();
      checks++;
      if (B1_OUT !== 18'h00155) begin failures++; $display("FAIL rmid_edge2 got=%h exp=%h", B1_OUT, 18'h00155); end
   endtask

   task automatic test_back_to_back();
      logic [17:0] vd [4] = '{18'd1, 18'd100, 18'h3FFFF, 18'd50};
      logic [17:0] vb [4] = '{18'd2, 18'd200, 18'd2, 18'd60};
      logic [1:0]  vo [4] = '{2'b01, 2'b11, 2'b01, 2'b00};
      logic [17:0] ve [4] = '{18'd3, 18'h3FF9C, 18'd1, 18'd60};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            D = vd[i]; B_BCIN_stg = vb[i]; OPMODE_PRE = vo[i];
         end
         tick();
         if (i >= 1) begin
            checks++;
            if (B1_OUT !== ve[i-1]) begin failures++; $display("FAIL b2b%0d got=%h exp=%h", i-1, B1_OUT, ve[i-1]); end
         end
      end
   endtask

   task automatic test_comb();
      c_d = 18'd10; c_b = 18'd4; c_op = 2'b11;
      #1;
      checks++;
      if (c_out !== 18'd6) begin failures++; $display("FAIL comb_sub got=%h exp=%h", c_out, 18'd6); end
      c_rst_n = 1'b0;
      #1;
      checks++;
      if (c_out !== 18'd6) begin failures++; $display("FAIL comb_rst got=%h exp=%h", c_out, 18'd6); end
      checks++;
      if (c_bcout !== 18'd6) begin failures++; $display("FAIL comb_bcout got=%h exp=%h", c_bcout, 18'd6); end
      c_op = 2'b01;
      #1;
      checks++;
      if (c_out !== 18'd14) begin failures++; $display("FAIL comb_add got=%h exp=%h", c_out, 18'd14); end
      c_rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_wrap();
      test_bypass();
      test_ceb_hold();
      test_ced_ceop();
      test_reset_mid();
      test_back_to_back();
      test_comb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
